// File: rtl/huffman_mcu_scheduler_if.sv
// Signal bundle between huffman_mcu_scheduler and its environment.
// The environment is the frame controller, the three block sources and the shared encoder.
interface huffman_mcu_scheduler_if;
  logic         frame_start;
  logic [15:0]  frame_mcus;
  logic [15:0]  restart_interval;
  logic         y_valid;
  logic         cb_valid;
  logic         cr_valid;
  logic [511:0] y_block;
  logic [511:0] cb_block;
  logic [511:0] cr_block;
  logic         y_ready;
  logic         cb_ready;
  logic         cr_ready;
  logic         enc_start;
  logic [511:0] enc_block;
  logic [1:0]   enc_comp;
  logic [8:0]   enc_dc_diff;
  logic         enc_done;
  logic         mcu_done;
  logic         rst_marker;
  logic         frame_done;
  logic [2:0]   rst_index;
  logic [15:0]  mcu_count;
  logic         busy;

  // master is the environment; slave is the scheduler itself
  modport master (
    output frame_start, frame_mcus, restart_interval,
    output y_valid, cb_valid, cr_valid, y_block, cb_block, cr_block,
    output enc_done,
    input  y_ready, cb_ready, cr_ready,
    input  enc_start, enc_block, enc_comp, enc_dc_diff,
    input  mcu_done, rst_marker, frame_done, rst_index, mcu_count, busy
  );

  modport slave (
    input  frame_start, frame_mcus, restart_interval,
    input  y_valid, cb_valid, cr_valid, y_block, cb_block, cr_block,
    input  enc_done,
    output y_ready, cb_ready, cr_ready,
    output enc_start, enc_block, enc_comp, enc_dc_diff,
    output mcu_done, rst_marker, frame_done, rst_index, mcu_count, busy
  );
endinterface

// File: rtl/huffman_mcu_scheduler.sv
// Sequences Y, Cb, Cr zigzag blocks of each MCU into one shared Huffman encoder.
// It also tracks DC predictors, MCU and restart counts, and RSTn marker numbering.
module huffman_mcu_scheduler (
  input logic                    clock,
  input logic                    reset,
  huffman_mcu_scheduler_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_BLK, LAUNCH, ENC_BUSY, MARKER} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      comp;
  logic [2:0][7:0] pred;
  logic [15:0]     frame_mcus_q;
  logic [15:0]     interval_q;
  logic [15:0]     rst_cnt;

  logic            sel_valid;
  logic [511:0]    sel_block;
  logic            frame_accept;
  logic            handshake;
  logic            enc_finish;
  logic [15:0]     mcu_count_inc;
  logic [15:0]     rst_cnt_inc;
  logic            last_mcu;
  logic            marker_due;

  // Only the source of the current component is ever looked at.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_block = bus.y_block;
    case (comp)
      2'd0: begin
        sel_valid = bus.y_valid;
        sel_block = bus.y_block;
      end
      2'd1: begin
        sel_valid = bus.cb_valid;
        sel_block = bus.cb_block;
      end
      2'd2: begin
        sel_valid = bus.cr_valid;
        sel_block = bus.cr_block;
      end
      default: ;
    endcase
  end

  assign frame_accept  = (state == IDLE) && bus.frame_start && (bus.frame_mcus != 16'd0);
  assign handshake     = (state == WAIT_BLK) && sel_valid;
  assign enc_finish    = (state == ENC_BUSY) && bus.enc_done;
  assign mcu_count_inc = bus.mcu_count + 16'd1;
  assign rst_cnt_inc   = rst_cnt + 16'd1;
  assign last_mcu      = (mcu_count_inc == frame_mcus_q);
  assign marker_due    = (interval_q != 16'd0) && (rst_cnt_inc == interval_q);

  assign bus.y_ready   = (state == WAIT_BLK) && (comp == 2'd0);
  assign bus.cb_ready  = (state == WAIT_BLK) && (comp == 2'd1);
  assign bus.cr_ready  = (state == WAIT_BLK) && (comp == 2'd2);

  // NOTE: state and datapath registers use non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.enc_start  = 1'b0;
    bus.rst_marker = 1'b0;
    bus.busy       = (state != IDLE);
    case (state)
      IDLE:     if (frame_accept) state_nxt = WAIT_BLK;
      WAIT_BLK: if (handshake) state_nxt = LAUNCH;
      LAUNCH: begin
        bus.enc_start = 1'b1;
        state_nxt     = ENC_BUSY;
      end
      ENC_BUSY: begin
        if (enc_finish) begin
          if (comp != 2'd2)    state_nxt = WAIT_BLK;
          else if (last_mcu)   state_nxt = IDLE;
          else if (marker_due) state_nxt = MARKER;
          else                 state_nxt = WAIT_BLK;
        end
      end
      MARKER: begin
        bus.rst_marker = 1'b1;
        state_nxt      = WAIT_BLK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the predictor array is only three bytes and must start at zero, so it is reset like any other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      comp            <= 2'd0;
      pred            <= '0;
      frame_mcus_q    <= 16'd0;
      interval_q      <= 16'd0;
      rst_cnt         <= 16'd0;
      bus.enc_block   <= '0;
      bus.enc_comp    <= 2'd0;
      bus.enc_dc_diff <= 9'd0;
      bus.mcu_done    <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.rst_index   <= 3'd0;
      bus.mcu_count   <= 16'd0;
    end else begin
      bus.mcu_done   <= 1'b0;
      bus.frame_done <= 1'b0;

      if (frame_accept) begin
        comp          <= 2'd0;
        pred          <= '0;
        frame_mcus_q  <= bus.frame_mcus;
        interval_q    <= bus.restart_interval;
        rst_cnt       <= 16'd0;
        bus.rst_index <= 3'd0;
        bus.mcu_count <= 16'd0;
      end

      // The DC difference wraps in 9 bits; an 8-bit signed delta always fits.
      if (handshake) begin
        bus.enc_block   <= sel_block;
        bus.enc_comp    <= comp;
        bus.enc_dc_diff <= {sel_block[7], sel_block[7:0]} - {pred[comp][7], pred[comp]};
        pred[comp]      <= sel_block[7:0];
      end

      if (enc_finish) begin
        if (comp == 2'd2) begin
          comp           <= 2'd0;
          bus.mcu_done   <= 1'b1;
          bus.frame_done <= last_mcu;
          bus.mcu_count  <= mcu_count_inc;
          rst_cnt        <= rst_cnt_inc;
        end else begin
          comp <= comp + 2'd1;
        end
      end

      // The marker index is shown during MARKER and advances as it leaves.
      if (state == MARKER) begin
        pred          <= '0;
        rst_cnt       <= 16'd0;
        bus.rst_index <= bus.rst_index + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_huffman_mcu_scheduler.sv
// Randomised scoreboard bench for huffman_mcu_scheduler.
// A frame-level reference model predicts encoder launches, MCU status and restart markers.
module tb_huffman_mcu_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b1;

  huffman_mcu_scheduler_if bus ();
  huffman_mcu_scheduler dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]   comp;
    logic [8:0]   diff;
    logic [511:0] blk;
  } launch_t;

  typedef struct {
    logic [15:0] count;
    logic        is_last;
  } mcu_t;

  launch_t    launch_q[$];
  mcu_t       mcu_q[$];
  logic [2:0] marker_q[$];
  logic [7:0] force_dc[$];
  logic [7:0] model_pred [3];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [511:0] actual, input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic ready_of(input int c);
    case (c)
      0:       return bus.y_ready;
      1:       return bus.cb_ready;
      default: return bus.cr_ready;
    endcase
  endfunction

  // Offer one block of component c, then act as the encoder for it.
  // With complete=0 it returns while the encoder is still busy.
  task automatic send_block(input int c, input logic [7:0] dc, input bit complete);
    logic [511:0] blk;
    launch_t      e;
    int           d;
    int           t;
    blk      = rand_block();
    blk[7:0] = dc;
    d        = int'($signed(dc)) - int'($signed(model_pred[c]));
    e.comp   = 2'(c);
    e.diff   = d[8:0];
    e.blk    = blk;
    launch_q.push_back(e);
    model_pred[c] = dc;

    if ($urandom_range(0, 3) == 0) begin
      bus.enc_done = 1'b1;
      @(negedge clock);
      bus.enc_done = 1'b0;
    end
    repeat ($urandom_range(0, 2)) @(negedge clock);
    bus.y_valid  = (c == 0) || ($urandom_range(0, 1) == 1);
    bus.cb_valid = (c == 1) || ($urandom_range(0, 1) == 1);
    bus.cr_valid = (c == 2) || ($urandom_range(0, 1) == 1);
    bus.y_block  = (c == 0) ? blk : rand_block();
    bus.cb_block = (c == 1) ? blk : rand_block();
    bus.cr_block = (c == 2) ? blk : rand_block();
    t = 0;
    while (!ready_of(c) && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("handshake_wait", t < 100, 1'b1);
    @(negedge clock);
    bus.y_valid  = 1'b0;
    bus.cb_valid = 1'b0;
    bus.cr_valid = 1'b0;
    t = 0;
    while (!bus.enc_start && t < 10) begin
      @(negedge clock);
      t++;
    end
    check("enc_start_wait", t < 10, 1'b1);
    @(negedge clock);
    if (!complete) return;

    if ($urandom_range(0, 3) == 0) begin
      bus.frame_start      = 1'b1;
      bus.frame_mcus       = 16'($urandom_range(1, 9));
      bus.restart_interval = 16'($urandom_range(0, 3));
      @(negedge clock);
      bus.frame_start = 1'b0;
    end
    repeat ($urandom_range(0, 3)) @(negedge clock);
    bus.enc_done = 1'b1;
    @(negedge clock);
    bus.enc_done = 1'b0;
  endtask

  task automatic start_frame(input int n, input int iv);
    for (int c = 0; c < 3; c++) model_pred[c] = 8'd0;
    bus.frame_mcus       = 16'(n);
    bus.restart_interval = 16'(iv);
    bus.frame_start      = 1'b1;
    @(negedge clock);
    bus.frame_start = 1'b0;
  endtask

  task automatic run_frame(input int n, input int iv);
    int         idx;
    int         t;
    logic [7:0] dc;
    mcu_t       m_exp;
    bit         marker;
    idx = 0;
    start_frame(n, iv);
    for (int m = 1; m <= n; m++) begin
      marker = (m != n) && (iv != 0) && (m % iv == 0);
      for (int c = 0; c < 3; c++) begin
        dc = (force_dc.size() > 0) ? force_dc.pop_front() : 8'($urandom);
        if (c == 2) begin
          m_exp.count   = 16'(m);
          m_exp.is_last = (m == n);
          mcu_q.push_back(m_exp);
          if (marker) marker_q.push_back(3'(idx));
        end
        send_block(c, dc, 1'b1);
      end
      if (marker) begin
        idx = (idx + 1) % 8;
        for (int c = 0; c < 3; c++) model_pred[c] = 8'd0;
      end
    end
    t = 0;
    while (bus.busy && t < 20) begin
      @(negedge clock);
      t++;
    end
    check("frame_end_wait", t < 20, 1'b1);
    repeat (2) @(negedge clock);
    check("mcu_count_hold", bus.mcu_count, 16'(n));
    check("busy_idle", bus.busy, 1'b0);
    check("launch_q_drained", launch_q.size(), 0);
    check("mcu_q_drained", mcu_q.size(), 0);
    check("marker_q_drained", marker_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_ready"}, {bus.y_ready, bus.cb_ready, bus.cr_ready}, 3'b000);
    check({tag, "_pulses"}, {bus.enc_start, bus.mcu_done, bus.rst_marker, bus.frame_done}, 4'b0000);
    check({tag, "_enc_block"}, bus.enc_block, 512'd0);
    check({tag, "_enc_comp"}, bus.enc_comp, 2'd0);
    check({tag, "_enc_dc_diff"}, bus.enc_dc_diff, 9'd0);
    check({tag, "_rst_index"}, bus.rst_index, 3'd0);
    check({tag, "_mcu_count"}, bus.mcu_count, 16'd0);
  endtask

  // Monitor: pops and compares whenever the DUT presents a launch or status pulse.
  initial begin
    launch_t    e;
    mcu_t       m;
    logic [2:0] ri;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (bus.enc_start) begin
          check("enc_start_expected", launch_q.size() > 0, 1'b1);
          if (launch_q.size() > 0) begin
            e = launch_q.pop_front();
            check("enc_comp", bus.enc_comp, e.comp);
            check("enc_dc_diff", bus.enc_dc_diff, e.diff);
            check("enc_block", bus.enc_block, e.blk);
          end
        end
        if (bus.mcu_done) begin
          check("mcu_done_expected", mcu_q.size() > 0, 1'b1);
          if (mcu_q.size() > 0) begin
            m = mcu_q.pop_front();
            check("mcu_count", bus.mcu_count, m.count);
            check("frame_done", bus.frame_done, m.is_last);
          end
        end else if (bus.frame_done) begin
          check("frame_done_with_mcu_done", bus.mcu_done, 1'b1);
        end
        if (bus.rst_marker) begin
          check("rst_marker_expected", marker_q.size() > 0, 1'b1);
          if (marker_q.size() > 0) begin
            ri = marker_q.pop_front();
            check("rst_index", bus.rst_index, ri);
          end
        end
        if (bus.y_ready || bus.cb_ready || bus.cr_ready)
          check("ready_onehot", $countones({bus.y_ready, bus.cb_ready, bus.cr_ready}), 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.frame_start      = 1'b0;
    bus.frame_mcus       = 16'd0;
    bus.restart_interval = 16'd0;
    bus.y_valid          = 1'b0;
    bus.cb_valid         = 1'b0;
    bus.cr_valid         = 1'b0;
    bus.y_block          = '0;
    bus.cb_block         = '0;
    bus.cr_block         = '0;
    bus.enc_done         = 1'b0;

    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    reset = 1'b0;
    @(negedge clock);

    // A zero-length frame request is ignored.
    start_frame(0, 0);
    @(negedge clock);
    check("zero_frame_busy", bus.busy, 1'b0);
    check("zero_frame_ready", bus.y_ready, 1'b0);

    // Single MCU with DC values 5, -3, 10.
    force_dc = '{8'd5, 8'hFD, 8'd10};
    run_frame(1, 0);

    // Y DC swings from 127 to -128, giving a -255 difference.
    force_dc = '{8'd127, 8'($urandom), 8'($urandom), 8'h80, 8'($urandom), 8'($urandom)};
    run_frame(2, 0);

    // Markers after every MCU, including index wrap past RST7.
    run_frame(3, 1);
    run_frame(10, 1);

    for (int k = 0; k < 5; k++) run_frame($urandom_range(1, 6), $urandom_range(0, 3));

    // Reset while the encoder is busy in MCU 2 abandons the frame.
    begin
      mcu_t m_exp;
      start_frame(4, 0);
      for (int c = 0; c < 3; c++) begin
        if (c == 2) begin
          m_exp.count   = 16'd1;
          m_exp.is_last = 1'b0;
          mcu_q.push_back(m_exp);
        end
        send_block(c, 8'($urandom), 1'b1);
      end
      send_block(0, 8'($urandom), 1'b0);
      check("pre_reset_busy", bus.busy, 1'b1);
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clock);
      reset = 1'b0;
      bus.enc_done = 1'b1;
      @(negedge clock);
      bus.enc_done = 1'b0;
      repeat (4) @(negedge clock);
      check("post_reset_busy", bus.busy, 1'b0);
      check("post_reset_mcu_count", bus.mcu_count, 16'd0);
      check("post_reset_ready", {bus.y_ready, bus.cb_ready, bus.cr_ready}, 3'b000);
    end

    run_frame(3, 2);

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
